axi4_write_fifo_slave: RTL and testbench
========================================

AXI4_WRITE_FIFO_SLAVE -- requirements
Module: axi4_write_fifo_slave

Interface
REQ-001 Parameter DATA_W, default 32, data bus width in bits; legal values are multiples of 8.
REQ-002 Parameter ADDR_W, default 32, address width in bits.
REQ-003 Parameter DEPTH, default 16, FIFO entries; legal values are powers of 2 and at least 2.
REQ-004 Parameter BASE_ADDR, default 0, lowest accepted address; used only with the REQ-027 macro.
REQ-005 Parameter ADDR_SIZE, default 'h1000, accepted window size in bytes; used only with the REQ-027 macro.
REQ-006 Ports, one per line (name, direction, width, meaning), SHALL be:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-low reset
  awaddr  in  ADDR_W  write address
  awvalid  in  1  address valid
  awready  out  1  address ready
  wdata  in  DATA_W  write data
  wstrb  in  DATA_W/8  byte strobes
  wvalid  in  1  data valid
  wready  out  1  data ready
  bresp  out  2  write response
  bvalid  out  1  response valid
  bready  in  1  response accept (1 bit)
  rd_en  in  1  pop request
  rd_addr  out  ADDR_W  head-entry address
  rd_data  out  DATA_W  head-entry data
  rd_strb  out  DATA_W/8  head-entry strobes
  empty  out  1  FIFO empty
  full  out  1  FIFO full
  count  out  log2(DEPTH)+1  occupied entries
REQ-007 Clocking and reset SHALL be one clock, clk; reset is synchronous and active-low.

Function
REQ-008 The AW channel SHALL use a one-entry holding register; awready = !aw_held; on awvalid&&awready, awaddr is latched and aw_held=1.
REQ-009 The W channel SHALL use an independent one-entry holding register; wready = !w_held; on wvalid&&wready, wdata/wstrb are latched and w_held=1.
REQ-010 AW and W SHALL be accepted in any order or in the same cycle; neither waits for the other.
REQ-011 push SHALL = aw_held && w_held && !full && (!bvalid || bready), evaluated combinationally.
REQ-012 On push, {addr,data,strb} SHALL be written at the write pointer, both holds cleared, and bvalid=1, bresp=2'b00 from the next cycle.
REQ-013 Latency: handshakes in cycle N with empty FIFO and bvalid=0 SHALL give bvalid=1 and empty=0 in cycle N+2.
REQ-014 bvalid SHALL stay high with bresp stable until bvalid&&bready, then drop unless a new push occurs in the same cycle.
REQ-015 When full, push SHALL be blocked even if rd_en is high in the same cycle; holds retain their contents and awready/wready stay low.
REQ-016 The read side SHALL be first-word fall-through; rd_addr/rd_data/rd_strb show the head combinationally when empty=0.
REQ-017 A pop SHALL occur on rd_en && !empty and advance the read pointer; rd_en while empty SHALL be ignored with no state change.
REQ-018 On simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-019 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = MSBs differ and LSBs equal; empty = pointers equal.
REQ-020 count SHALL = wr_ptr - rd_ptr, modulo 2*DEPTH.
REQ-021 An all-zero wstrb SHALL be stored and responded to like any other write; no special casing.

Reset
REQ-022 While reset=0 at a clk edge, aw_held, w_held, bvalid and both pointers SHALL clear to 0.
REQ-023 During and after reset: bresp=2'b00, awready=0 and wready=0 during reset, then 1 after; empty=1, full=0, count=0.
REQ-024 Reset mid-transaction SHALL drop held beats, pending responses and FIFO contents; none reappear after reset.
REQ-025 FIFO storage and holding-register data SHALL not require reset.

Configuration
REQ-026 The macro AXI_SLAVE_ADDR_CHECK_EN SHALL select address checking.
REQ-027 With it defined: an awaddr outside [BASE_ADDR, BASE_ADDR+ADDR_SIZE) is not written to the FIFO; the response is bresp=2'b10 (SLVERR); handshake and bvalid timing are identical to REQ-011..REQ-014; a blocked push due to full also applies.
REQ-028 Without it: no address comparison; every write is stored with bresp=2'b00; BASE_ADDR and ADDR_SIZE are ignored.

Verification
REQ-029 Same-cycle AW=0x10 and W=0xDEADBEEF with wstrb=0xF, bready=1 -> bvalid=1, bresp=00 two cycles later; rd_data=0xDEADBEEF, rd_addr=0x10, count=1.
REQ-030 W beat 3 cycles before AW -> wready=0 after the W handshake until the push; exactly one entry and one response.
REQ-031 17 writes with DEPTH=16 and no pops -> full=1, count=16; the 17th is held with awready=wready=0; one pop releases it the next cycle.
REQ-032 bready=0 for 5 cycles after the first response -> bvalid held, bresp stable; a second write pair stays held until bready=1.
REQ-033 Reset=0 with one entry stored and one W held -> after reset: empty=1, count=0, bvalid=0; no response for the dropped beat.
REQ-034 With macro defined, BASE_ADDR=0x1000 and ADDR_SIZE=0x100: write to 0x2000 -> bresp=10, count unchanged; write to 0x1004 -> bresp=00, count+1.

Source files
------------

// File: rtl/axi4_write_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi4_write_fifo_slave
// Purpose  : AXI4 write-only slave. Each AW/W pair becomes one FIFO entry
//            {addr, data, strb}. The FIFO is read locally through a
//            first-word fall-through pop port.
// Option   : define AXI_SLAVE_ADDR_CHECK_EN to reject addresses outside
//            [BASE_ADDR, BASE_ADDR+ADDR_SIZE) with SLVERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_write_fifo_slave #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W:0]   ADDR_SIZE = 'h1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      awaddr,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [DATA_W-1:0]      wdata,
  input  logic [DATA_W/8-1:0]    wstrb,
  input  logic                   wvalid,
  output logic                   wready,
  output logic [1:0]             bresp,
  output logic                   bvalid,
  input  logic                   bready,
  input  logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [DATA_W/8-1:0]    rd_strb,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Channel holding registers
  logic              aw_held;
  logic              w_held;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;

  // Response state
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [STRB_W-1:0] mem_strb [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  logic              addr_ok;
  logic              accept;
  logic              push;
  logic              pop;

  // Ready is forced low while reset is asserted so no beat is taken in reset
  assign awready = reset && !aw_held;
  assign wready  = reset && !w_held;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign count = wr_ptr - rd_ptr;

`ifdef AXI_SLAVE_ADDR_CHECK_EN
  // One extra bit keeps BASE_ADDR+ADDR_SIZE from wrapping at the top of space
  logic [ADDR_W:0] addr_ext;
  logic [ADDR_W:0] win_lo;
  logic [ADDR_W:0] win_hi;
  assign addr_ext = {1'b0, aw_addr_q};
  assign win_lo   = {1'b0, BASE_ADDR};
  assign win_hi   = win_lo + ADDR_SIZE;
  assign addr_ok  = (addr_ext >= win_lo) && (addr_ext < win_hi);
`else
  assign addr_ok  = 1'b1;
`endif

  // A complete pair retires only when there is room and the B slot is free;
  // rejected addresses retire the pair but skip the FIFO write.
  assign accept = aw_held && w_held && !full && (!bvalid_q || bready);
  assign push   = accept && addr_ok;
  assign pop    = rd_en && !empty;

  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;

  // First-word fall-through: head entry is always visible
  assign rd_addr = mem_addr[rd_ptr[IDX_W-1:0]];
  assign rd_data = mem_data[rd_ptr[IDX_W-1:0]];
  assign rd_strb = mem_strb[rd_ptr[IDX_W-1:0]];

  // AW hold flag: set on handshake, cleared when the pair retires
  always_ff @(posedge clk) begin
    if (!reset) begin
      aw_held <= 1'b0;
    end else if (awvalid && awready) begin
      aw_held <= 1'b1;
    end else if (accept) begin
      aw_held <= 1'b0;
    end
  end

  // W hold flag: independent of AW so either channel may arrive first
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_held <= 1'b0;
    end else if (wvalid && wready) begin
      w_held <= 1'b1;
    end else if (accept) begin
      w_held <= 1'b0;
    end
  end

  // Holding-register payloads; no reset needed, guarded by the hold flags
  always_ff @(posedge clk) begin
    if (awvalid && awready) begin
      aw_addr_q <= awaddr;
    end
    if (wvalid && wready) begin
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // Write response: raised on retire, held until the master accepts it
  always_ff @(posedge clk) begin
    if (!reset) begin
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else if (accept) begin
      bvalid_q <= 1'b1;
      bresp_q  <= addr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // FIFO storage write; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr[IDX_W-1:0]] <= aw_addr_q;
      mem_data[wr_ptr[IDX_W-1:0]] <= w_data_q;
      mem_strb[wr_ptr[IDX_W-1:0]] <= w_strb_q;
    end
  end

  // Pointer update; push and pop may both advance in one cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi4_write_fifo_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_write_fifo_slave
// Purpose  : Directed self-checking bench for axi4_write_fifo_slave
//            (DATA_W=32, ADDR_W=32, DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_write_fifo_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_strb;
  logic        empty;
  logic        full;
  logic [4:0]  count;

  int compared   = 0;
  int mismatched = 0;

  axi4_write_fifo_slave #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_strb(rd_strb),
    .empty(empty), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same-cycle AW+W handshake, then one more cycle so the pair can retire
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0;
    wvalid = 1'b0; bready = 1'b1; rd_en = 1'b0;

    // ---- reset state ----
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_wready",  wready,  0);
    chk("rst_empty",   empty,   1);
    chk("rst_full",    full,    0);
    chk("rst_count",   count,   0);
    chk("rst_bvalid",  bvalid,  0);
    chk("rst_bresp",   bresp,   0);
    reset = 1'b1;
    #1;
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready",  wready,  1);
    tick();

    // ---- same-cycle AW and W, latency of two cycles ----
    awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_n1_bvalid",  bvalid,  0);
    chk("t1_n1_empty",   empty,   1);
    chk("t1_n1_awready", awready, 0);
    tick();
    chk("t1_bvalid",  bvalid,  1);
    chk("t1_bresp",   bresp,   0);
    chk("t1_empty",   empty,   0);
    chk("t1_rd_data", rd_data, 32'hDEADBEEF);
    chk("t1_rd_addr", rd_addr, 32'h10);
    chk("t1_rd_strb", rd_strb, 4'hF);
    chk("t1_count",   count,   1);
    tick();
    chk("t1_bvalid_drop", bvalid,  0);
    chk("t1_awready_back", awready, 1);
    pop1();
    chk("t1_pop_empty", empty, 1);
    chk("t1_pop_count", count, 0);

    // ---- pop while empty is ignored ----
    pop1();
    chk("empty_pop_count", count, 0);
    chk("empty_pop_empty", empty, 1);
    chk("empty_pop_full",  full,  0);

    // ---- W three cycles ahead of AW ----
    wdata = 32'h11112222; wstrb = 4'h3; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_0", wready, 0);
    tick();
    chk("t2_wready_1", wready, 0);
    chk("t2_bvalid_1", bvalid, 0);
    tick();
    chk("t2_wready_2", wready, 0);
    awaddr = 32'h20; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2_wready_3", wready, 0);
    chk("t2_bvalid_3", bvalid, 0);
    tick();
    chk("t2_bvalid",  bvalid,  1);
    chk("t2_count",   count,   1);
    chk("t2_rd_addr", rd_addr, 32'h20);
    chk("t2_rd_data", rd_data, 32'h11112222);
    chk("t2_rd_strb", rd_strb, 4'h3);
    chk("t2_wready",  wready,  1);
    tick();
    chk("t2_one_resp",  bvalid, 0);
    chk("t2_one_entry", count,  1);
    pop1();

    // ---- fill to 16, 17th held, one pop releases it ----
    for (int i = 0; i < 16; i++) begin
      wr(32'h100 + 32'(4 * i), 32'hA0000000 + 32'(i), (i == 0) ? 4'h0 : 4'hF);
    end
    chk("t3_full16",     full,    1);
    chk("t3_count16",    count,   16);
    chk("t3_zero_strb",  rd_strb, 4'h0);
    chk("t3_head_data",  rd_data, 32'hA0000000);
    wr(32'h140, 32'hA0000010, 4'hF);
    chk("t3_blk_awready", awready, 0);
    chk("t3_blk_wready",  wready,  0);
    chk("t3_blk_count",   count,   16);
    chk("t3_blk_bvalid",  bvalid,  0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("t3_pop_count",   count,   15);
    chk("t3_pop_full",    full,    0);
    chk("t3_pop_head",    rd_data, 32'hA0000001);
    chk("t3_pop_bvalid",  bvalid,  0);
    tick();
    chk("t3_rel_count",   count,   16);
    chk("t3_rel_full",    full,    1);
    chk("t3_rel_bvalid",  bvalid,  1);
    chk("t3_rel_awready", awready, 1);
    for (int i = 0; i < 15; i++) pop1();
    chk("t3_last_data",  rd_data, 32'hA0000010);
    chk("t3_last_addr",  rd_addr, 32'h140);
    chk("t3_last_count", count,   1);
    pop1();
    chk("t3_drained", empty, 1);

    // ---- back-pressure on B ----
    bready = 1'b0;
    wr(32'h200, 32'hCAFE0001, 4'hF);
    chk("t4_bvalid", bvalid, 1);
    awaddr = 32'h204; wdata = 32'hCAFE0002; wstrb = 4'hC;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_hold_bvalid",  bvalid,  1);
      chk("t4_hold_bresp",   bresp,   0);
      chk("t4_hold_awready", awready, 0);
      chk("t4_hold_count",   count,   1);
      tick();
    end
    bready = 1'b1;
    tick();
    chk("t4_second_bvalid", bvalid, 1);
    chk("t4_second_count",  count,  2);
    chk("t4_head_data",     rd_data, 32'hCAFE0001);
    tick();
    chk("t4_bvalid_drop", bvalid, 0);
    pop1();
    chk("t4_second_data", rd_data, 32'hCAFE0002);
    chk("t4_second_strb", rd_strb, 4'hC);
    pop1();

`ifdef AXI_SLAVE_ADDR_CHECK_EN
    // ---- default window is [0, 0x1000) ----
    wr(32'h2000, 32'h0BAD0BAD, 4'hF);
    chk("t6_bad_bvalid", bvalid, 1);
    chk("t6_bad_bresp",  bresp,  2'b10);
    chk("t6_bad_count",  count,  0);
    tick();
    wr(32'h4, 32'h600D600D, 4'hF);
    chk("t6_ok_bresp", bresp,   2'b00);
    chk("t6_ok_count", count,   1);
    chk("t6_ok_data",  rd_data, 32'h600D600D);
    tick();
    pop1();
`endif

    // ---- reset mid-transaction ----
    wr(32'h300, 32'h33333333, 4'hF);
    wdata = 32'h44444444; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t5_pre_count",  count,  1);
    chk("t5_pre_wready", wready, 0);
    reset = 1'b0;
    tick();
    chk("t5_rst_awready", awready, 0);
    chk("t5_rst_wready",  wready,  0);
    reset = 1'b1;
    #1;
    chk("t5_empty",   empty,  1);
    chk("t5_count",   count,  0);
    chk("t5_bvalid",  bvalid, 0);
    chk("t5_wready",  wready, 1);
    awaddr = 32'h304; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    tick(); tick();
    chk("t5_no_resp",  bvalid, 0);
    chk("t5_no_entry", empty,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
